// File: rtl/mem_ctrl_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: FSM states, LSB size codes,
// grant owners and the size-to-byte-count helper.
package mem_ctrl_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE     = 2'b00,
        SZ_HALF     = 2'b01,
        SZ_WORD     = 2'b10,
        SZ_WORD_ALT = 2'b11
    } lsb_size_t;

    typedef enum logic {
        GR_IF  = 1'b0,
        GR_LSB = 1'b1
    } grant_t;

    localparam logic       VALID         = 1'b1;
    localparam logic       INVALID       = 1'b0;
    localparam logic [7:0] NULL_BYTE     = 8'h00;
    localparam logic [1:0] IO_HI_DEFAULT = 2'b11;

    // Code 11 is not a legal LSB size; it is serviced as a word.
    function automatic logic [2:0] size_to_len(input lsb_size_t size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_byte_sequencer.sv
// Per-access byte sequencer: holds base address, length and store data, counts
// bytes and assembles little-endian read lanes for the arbiter.
module mem_byte_sequencer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DATA_W / 8) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              load,
    input  logic              advance,
    input  logic              capture,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [CNT_W-1:0]  load_len,
    input  logic [DATA_W-1:0] load_wdata,
    input  logic [7:0]        mem_din,
    output logic [CNT_W-1:0]  cnt,
    output logic [CNT_W-1:0]  len,
    output logic [ADDR_W-1:0] cur_addr,
    output logic [ADDR_W-1:0] nxt_addr,
    output logic [7:0]        cur_byte,
    output logic [DATA_W-1:0] rd_word
);

    localparam int LANE_W = CNT_W - 1;

    logic [ADDR_W-1:0] base;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rd_buf;
    logic [LANE_W-1:0] wr_lane;
    logic [LANE_W-1:0] cap_lane;

    // Read data for lane k arrives while the counter already points at k+1.
    assign wr_lane  = cnt[LANE_W-1:0];
    assign cap_lane = cnt[LANE_W-1:0] - 1'b1;
    assign cur_addr = base + ADDR_W'(cnt);
    assign nxt_addr = cur_addr + 1'b1;
    assign cur_byte = wdata[8*wr_lane +: 8];

    always_comb begin
        rd_word = rd_buf;
        rd_word[8*cap_lane +: 8] = mem_din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base   <= '0;
            len    <= '0;
            wdata  <= '0;
            cnt    <= '0;
            rd_buf <= '0;
        end else if (rdy) begin
            if (load) begin
                base   <= load_addr;
                len    <= load_len;
                wdata  <= load_wdata;
                cnt    <= advance ? CNT_W'(1) : '0;
                rd_buf <= '0;
            end else begin
                if (advance) cnt <= cnt + 1'b1;
                if (capture) rd_buf <= rd_word;
            end
        end
    end

endmodule

// File: rtl/mem_ctrl_arbiter.sv
// Owner of the 8-bit RAM/IO port: round-robin arbitration between instruction
// fetch and the load/store buffer, byte-serial sequencing, IO stall and flush.
module mem_ctrl_arbiter
    import mem_ctrl_arbiter_pkg::*;
#(
    parameter int         ADDR_W = 32,
    parameter int         DATA_W = 32,
    parameter logic [1:0] IO_HI  = IO_HI_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full,
    input  logic              flush,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_data,
    input  logic              lsb_req,
    input  logic              lsb_wr,
    input  logic [1:0]        lsb_size,
    input  logic [ADDR_W-1:0] lsb_addr,
    input  logic [DATA_W-1:0] lsb_wdata,
    output logic              lsb_done,
    output logic [DATA_W-1:0] lsb_rdata
);

    localparam int CNT_W = $clog2(DATA_W / 8) + 1;

    state_t state, state_nxt;
    grant_t last_grant, last_grant_nxt;
    grant_t owner, owner_nxt;

    logic [ADDR_W-1:0] mem_a_nxt;
    logic [7:0]        mem_dout_nxt;
    logic              mem_wr_nxt;
    logic              if_done_nxt, lsb_done_nxt;
    logic [DATA_W-1:0] if_data_nxt, lsb_rdata_nxt;

    logic              seq_load, seq_adv, seq_cap;
    logic [ADDR_W-1:0] load_addr;
    logic [CNT_W-1:0]  load_len;
    logic [DATA_W-1:0] load_wdata;
    logic [CNT_W-1:0]  seq_cnt, seq_len;
    logic [ADDR_W-1:0] seq_cur_addr, seq_nxt_addr;
    logic [7:0]        seq_cur_byte;
    logic [DATA_W-1:0] seq_rd_word;

    logic if_elig, lsb_elig, pick_lsb;

    function automatic logic io_stall(input logic full, input logic [ADDR_W-1:0] a);
        return full && (a[17:16] == IO_HI);
    endfunction

    mem_byte_sequencer #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_seq (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .load       (seq_load),
        .advance    (seq_adv),
        .capture    (seq_cap),
        .load_addr  (load_addr),
        .load_len   (load_len),
        .load_wdata (load_wdata),
        .mem_din    (mem_din),
        .cnt        (seq_cnt),
        .len        (seq_len),
        .cur_addr   (seq_cur_addr),
        .nxt_addr   (seq_nxt_addr),
        .cur_byte   (seq_cur_byte),
        .rd_word    (seq_rd_word)
    );

    // A requester whose done is high this cycle is about to drop its request.
    assign if_elig  = if_req && !if_done && !flush;
    assign lsb_elig = lsb_req && !lsb_done;
    assign pick_lsb = lsb_elig && (!if_elig || last_grant == GR_IF);

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        owner_nxt      = owner;
        mem_a_nxt      = '0;
        mem_dout_nxt   = NULL_BYTE;
        mem_wr_nxt     = INVALID;
        if_done_nxt    = INVALID;
        lsb_done_nxt   = INVALID;
        if_data_nxt    = if_data;
        lsb_rdata_nxt  = lsb_rdata;
        seq_load       = 1'b0;
        seq_adv        = 1'b0;
        seq_cap        = 1'b0;
        load_addr      = '0;
        load_len       = '0;
        load_wdata     = '0;

        case (state)
            ST_IDLE: begin
                if (if_elig || lsb_elig) begin
                    seq_load = 1'b1;
                    if (pick_lsb) begin
                        owner_nxt      = GR_LSB;
                        last_grant_nxt = GR_LSB;
                        load_addr      = lsb_addr;
                        load_len       = CNT_W'(size_to_len(lsb_size_t'(lsb_size)));
                        load_wdata     = lsb_wdata;
                        if (lsb_wr) begin
                            state_nxt = ST_WRITE;
                            // Byte 0 goes out on the grant edge unless the IO sink is full.
                            if (!io_stall(io_buffer_full, lsb_addr)) begin
                                seq_adv      = 1'b1;
                                mem_wr_nxt   = VALID;
                                mem_a_nxt    = lsb_addr;
                                mem_dout_nxt = lsb_wdata[7:0];
                            end
                        end else begin
                            state_nxt = ST_READ;
                            mem_a_nxt = lsb_addr;
                        end
                    end else begin
                        owner_nxt      = GR_IF;
                        last_grant_nxt = GR_IF;
                        load_addr      = if_addr;
                        load_len       = CNT_W'(DATA_W / 8);
                        state_nxt      = ST_READ;
                        mem_a_nxt      = if_addr;
                    end
                end
            end

            ST_READ: begin
                if (flush) begin
                    state_nxt = ST_IDLE;
                end else if (seq_cnt == seq_len) begin
                    state_nxt = ST_IDLE;
                    if (owner == GR_IF) begin
                        if_done_nxt = VALID;
                        if_data_nxt = seq_rd_word;
                    end else begin
                        lsb_done_nxt  = VALID;
                        lsb_rdata_nxt = seq_rd_word;
                    end
                end else begin
                    seq_adv = 1'b1;
                    seq_cap = (seq_cnt != '0);
                    if (seq_cnt + 1'b1 < seq_len) mem_a_nxt = seq_nxt_addr;
                end
            end

            ST_WRITE: begin
                if (seq_cnt == seq_len) begin
                    state_nxt    = ST_IDLE;
                    lsb_done_nxt = VALID;
                end else if (!io_stall(io_buffer_full, seq_cur_addr)) begin
                    seq_adv      = 1'b1;
                    mem_wr_nxt   = VALID;
                    mem_a_nxt    = seq_cur_addr;
                    mem_dout_nxt = seq_cur_byte;
                end
            end

            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_grant <= GR_IF;
            owner      <= GR_IF;
            mem_a      <= '0;
            mem_dout   <= '0;
            mem_wr     <= 1'b0;
            if_done    <= 1'b0;
            lsb_done   <= 1'b0;
            if_data    <= '0;
            lsb_rdata  <= '0;
        end else if (rdy) begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            owner      <= owner_nxt;
            mem_a      <= mem_a_nxt;
            mem_dout   <= mem_dout_nxt;
            mem_wr     <= mem_wr_nxt;
            if_done    <= if_done_nxt;
            lsb_done   <= lsb_done_nxt;
            if_data    <= if_data_nxt;
            lsb_rdata  <= lsb_rdata_nxt;
        end
    end

endmodule

// File: tb/tb_mem_ctrl_arbiter.sv
// Directed bench for mem_ctrl_arbiter: a transaction table plus hand-written
// sequences for arbitration, IO stall, flush, rdy freeze and reset.
module tb_mem_ctrl_arbiter;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full, flush;
    logic        if_req, if_done;
    logic [31:0] if_addr, if_data;
    logic        lsb_req, lsb_wr, lsb_done;
    logic [1:0]  lsb_size;
    logic [31:0] lsb_addr, lsb_wdata, lsb_rdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_ctrl_arbiter #(
        .ADDR_W (32),
        .DATA_W (32),
        .IO_HI  (2'b11)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .io_buffer_full (io_buffer_full),
        .flush          (flush),
        .if_req         (if_req),
        .if_addr        (if_addr),
        .if_done        (if_done),
        .if_data        (if_data),
        .lsb_req        (lsb_req),
        .lsb_wr         (lsb_wr),
        .lsb_size       (lsb_size),
        .lsb_addr       (lsb_addr),
        .lsb_wdata      (lsb_wdata),
        .lsb_done       (lsb_done),
        .lsb_rdata      (lsb_rdata)
    );

    // RAM model: synchronous read, in the same rdy domain as the controller.
    logic [7:0] ram [0:4095];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4096; i++) ram[i] <= 8'h00;
            ram[12'h100] <= 8'h13; ram[12'h101] <= 8'h00; ram[12'h102] <= 8'h00; ram[12'h103] <= 8'h93;
            ram[12'h104] <= 8'h37; ram[12'h105] <= 8'h45; ram[12'h106] <= 8'h23; ram[12'h107] <= 8'h01;
            ram[12'h300] <= 8'hAA; ram[12'h301] <= 8'hBB; ram[12'h302] <= 8'hCC; ram[12'h303] <= 8'hDD;
            ram[12'hFFE] <= 8'h11; ram[12'hFFF] <= 8'h22; ram[12'h000] <= 8'h33; ram[12'h001] <= 8'h44;
            mem_din <= 8'h00;
        end else if (rdy) begin
            if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
            mem_din <= ram[mem_a[11:0]];
        end
    end

    typedef struct {
        logic        is_if;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        int          exp_lat;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_idle();
        rdy = 1'b1; io_buffer_full = 1'b0; flush = 1'b0;
        if_req = 1'b0; if_addr = '0;
        lsb_req = 1'b0; lsb_wr = 1'b0; lsb_size = 2'b00; lsb_addr = '0; lsb_wdata = '0;
    endtask

    // Entered at a negedge with the DUT idle; that cycle is cycle 0.
    task automatic run_txn(input vec_t v, input string name);
        int lat = -1;
        logic [31:0] data = '0;
        logic stray = 1'b0;
        if (v.is_if) begin
            if_req = 1'b1; if_addr = v.addr;
        end else begin
            lsb_req = 1'b1; lsb_wr = v.wr; lsb_size = v.size; lsb_addr = v.addr; lsb_wdata = v.wdata;
        end
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (lat < 0) begin
                if (v.is_if ? if_done : lsb_done) begin
                    lat = c;
                    data = v.is_if ? if_data : lsb_rdata;
                    if_req = 1'b0; lsb_req = 1'b0;
                end
                if (v.is_if ? lsb_done : if_done) stray = 1'b1;
            end
        end
        set_idle();
        check({name, "_lat"}, lat, v.exp_lat);
        if (!v.wr) check({name, "_data"}, data, v.exp_data);
        check({name, "_other_done"}, {31'd0, stray}, 32'd0);
    endtask

    int          lsb_cyc, if_cyc;
    logic [31:0] lsb_val, if_val;
    logic        seen;
    vec_t        tv;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 2'b10, 32'h0000_0100, 32'h0,          32'h9300_0013, 6};
        vecs[1]  = '{1'b1, 1'b0, 2'b10, 32'h0000_0104, 32'h0,          32'h0123_4537, 6};
        vecs[2]  = '{1'b0, 1'b0, 2'b00, 32'h0000_0300, 32'h0,          32'h0000_00AA, 3};
        vecs[3]  = '{1'b0, 1'b0, 2'b01, 32'h0000_0301, 32'h0,          32'h0000_CCBB, 4};
        vecs[4]  = '{1'b0, 1'b0, 2'b10, 32'h0000_0300, 32'h0,          32'hDDCC_BBAA, 6};
        vecs[5]  = '{1'b0, 1'b0, 2'b11, 32'h0000_0300, 32'h0,          32'hDDCC_BBAA, 6};
        vecs[6]  = '{1'b0, 1'b0, 2'b10, 32'hFFFF_FFFE, 32'h0,          32'h4433_2211, 6};
        vecs[7]  = '{1'b0, 1'b1, 2'b10, 32'h0000_0204, 32'hCAFE_F00D, 32'h0,          5};
        vecs[8]  = '{1'b0, 1'b0, 2'b10, 32'h0000_0204, 32'h0,          32'hCAFE_F00D, 6};
        vecs[9]  = '{1'b0, 1'b1, 2'b00, 32'h0000_0208, 32'h1234_567F, 32'h0,          2};
        vecs[10] = '{1'b0, 1'b0, 2'b10, 32'h0000_0208, 32'h0,          32'h0000_007F, 6};

        set_idle();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_mem_a", mem_a, 32'h0);
        check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        check("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
        check("rst_if_done", {31'd0, if_done}, 32'd0);
        check("rst_lsb_done", {31'd0, lsb_done}, 32'd0);
        check("rst_if_data", if_data, 32'h0);
        check("rst_lsb_rdata", lsb_rdata, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Simultaneous requests after reset: LSB first, IF in the next IDLE.
        if_req = 1'b1; if_addr = 32'h100;
        lsb_req = 1'b1; lsb_wr = 1'b0; lsb_size = 2'b10; lsb_addr = 32'h300;
        lsb_cyc = -1; if_cyc = -1; lsb_val = '0; if_val = '0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (lsb_done && lsb_cyc < 0) begin lsb_cyc = c; lsb_val = lsb_rdata; lsb_req = 1'b0; end
            if (if_done && if_cyc < 0) begin if_cyc = c; if_val = if_data; if_req = 1'b0; end
        end
        set_idle();
        check("tie_lsb_cycle", lsb_cyc, 32'd6);
        check("tie_lsb_data", lsb_val, 32'hDDCC_BBAA);
        check("tie_if_cycle", if_cyc, 32'd12);
        check("tie_if_data", if_val, 32'h9300_0013);

        for (int i = 0; i < 11; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        // Store half: bus trace.
        lsb_req = 1'b1; lsb_wr = 1'b1; lsb_size = 2'b01; lsb_addr = 32'h200; lsb_wdata = 32'h0000_BEEF;
        @(negedge clk);
        check("sth_c1_wr", {31'd0, mem_wr}, 32'd1);
        check("sth_c1_a", mem_a, 32'h200);
        check("sth_c1_dout", {24'd0, mem_dout}, 32'hEF);
        @(negedge clk);
        check("sth_c2_wr", {31'd0, mem_wr}, 32'd1);
        check("sth_c2_a", mem_a, 32'h201);
        check("sth_c2_dout", {24'd0, mem_dout}, 32'hBE);
        @(negedge clk);
        check("sth_c3_done", {31'd0, lsb_done}, 32'd1);
        check("sth_c3_wr", {31'd0, mem_wr}, 32'd0);
        check("sth_c3_a", mem_a, 32'h0);
        check("sth_c3_dout", {24'd0, mem_dout}, 32'h0);
        set_idle();
        @(negedge clk);
        check("sth_ram200", {24'd0, ram[12'h200]}, 32'hEF);
        check("sth_ram201", {24'd0, ram[12'h201]}, 32'hBE);
        check("sth_ram202", {24'd0, ram[12'h202]}, 32'h00);

        // IO-region store held off while the IO sink is full.
        lsb_req = 1'b1; lsb_wr = 1'b1; lsb_size = 2'b00; lsb_addr = 32'h0003_0000; lsb_wdata = 32'h41;
        io_buffer_full = 1'b1;
        @(negedge clk);
        check("io_c1_wr", {31'd0, mem_wr}, 32'd0);
        @(negedge clk);
        check("io_c2_wr", {31'd0, mem_wr}, 32'd0);
        @(negedge clk);
        check("io_c3_wr", {31'd0, mem_wr}, 32'd0);
        io_buffer_full = 1'b0;
        @(negedge clk);
        check("io_c4_wr", {31'd0, mem_wr}, 32'd1);
        check("io_c4_a", mem_a, 32'h0003_0000);
        check("io_c4_dout", {24'd0, mem_dout}, 32'h41);
        check("io_c4_done", {31'd0, lsb_done}, 32'd0);
        @(negedge clk);
        check("io_c5_done", {31'd0, lsb_done}, 32'd1);
        set_idle();
        @(negedge clk);

        // Flush aborts an IF read in cycle 3.
        if_req = 1'b1; if_addr = 32'h104;
        repeat (2) @(negedge clk);
        check("fl_c2_a", mem_a, 32'h105);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        check("fl_c4_a", mem_a, 32'h0);
        check("fl_c4_wr", {31'd0, mem_wr}, 32'd0);
        flush = 1'b0; if_req = 1'b0;
        seen = if_done;
        for (int c = 5; c <= 12; c++) begin
            @(negedge clk);
            if (if_done) seen = 1'b1;
        end
        check("fl_no_if_done", {31'd0, seen}, 32'd0);

        // Flush in IDLE blocks the IF grant.
        if_req = 1'b1; if_addr = 32'h100; flush = 1'b1;
        @(negedge clk);
        check("fl_idle_c1_a", mem_a, 32'h0);
        @(negedge clk);
        flush = 1'b0;
        if_cyc = -1; if_val = '0;
        for (int c = 3; c <= 16; c++) begin
            @(negedge clk);
            if (if_done && if_cyc < 0) begin if_cyc = c; if_val = if_data; if_req = 1'b0; end
        end
        set_idle();
        check("fl_idle_if_cycle", if_cyc, 32'd8);
        check("fl_idle_if_data", if_val, 32'h9300_0013);

        // A store is committed even with flush asserted mid-access.
        lsb_req = 1'b1; lsb_wr = 1'b1; lsb_size = 2'b10; lsb_addr = 32'h210; lsb_wdata = 32'h1122_3344;
        lsb_cyc = -1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            flush = (c == 1 || c == 2);
            if (lsb_done && lsb_cyc < 0) begin lsb_cyc = c; lsb_req = 1'b0; end
        end
        set_idle();
        check("fl_store_cycle", lsb_cyc, 32'd5);
        tv = '{1'b0, 1'b0, 2'b10, 32'h0000_0210, 32'h0, 32'h1122_3344, 6};
        run_txn(tv, "fl_store_readback");

        // rdy low for cycles 3 and 4 of a word load.
        lsb_req = 1'b1; lsb_wr = 1'b0; lsb_size = 2'b10; lsb_addr = 32'h300;
        repeat (3) @(negedge clk);
        check("rdy_c3_a", mem_a, 32'h302);
        rdy = 1'b0;
        @(negedge clk);
        check("rdy_c4_a", mem_a, 32'h302);
        @(negedge clk);
        rdy = 1'b1;
        check("rdy_c5_a", mem_a, 32'h302);
        lsb_cyc = -1; lsb_val = '0;
        for (int c = 6; c <= 16; c++) begin
            @(negedge clk);
            if (lsb_done && lsb_cyc < 0) begin lsb_cyc = c; lsb_val = lsb_rdata; lsb_req = 1'b0; end
        end
        set_idle();
        check("rdy_done_cycle", lsb_cyc, 32'd8);
        check("rdy_data", lsb_val, 32'hDDCC_BBAA);

        // Reset in the middle of a word load.
        lsb_req = 1'b1; lsb_wr = 1'b0; lsb_size = 2'b10; lsb_addr = 32'h300;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_a", mem_a, 32'h0);
        check("rstmid_rdata", lsb_rdata, 32'h0);
        rst = 1'b0; lsb_req = 1'b0;
        seen = lsb_done;
        for (int c = 5; c <= 12; c++) begin
            @(negedge clk);
            if (lsb_done) seen = 1'b1;
        end
        check("rstmid_no_done", {31'd0, seen}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
